// File: rtl/core_mem_resp.sv
// core_mem_resp: single-port doubleword memory serving core fetch and load/store ports with WAIT_CYCLES busy cycles.
// Optional one-entry fetch buffer enabled by defining MEM_RESP_IFETCH_BUF_EN.
module core_mem_resp #(
    parameter int    DEPTH       = 4096,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_rd_en_i,
    input  logic [63:0] pc_i,
    input  logic        mem_rd_en_i,
    input  logic [63:0] addr_mem_rd_i,
    input  logic        mem_wr_en_i,
    input  logic [63:0] addr_mem_wr_i,
    input  logic [63:0] data_mem_wr_i,
    output logic [31:0] instr_o,
    output logic [63:0] addr_instr_o,
    output logic [63:0] data_mem_o,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        axi_idle_if_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, D_BUSY, D_DONE, I_BUSY, I_DONE} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt;
    logic [63:0]   mem [DEPTH];
    logic          op_wr, fetch_ok, buf_hit;
    logic [AW-1:0] d_idx, d_ai, f_idx;
    logic [63:0]   wdata, i_pc, d_wd, f_pc, f_dw;
    logic          d_req, d_wr, d_fire, i_fire, f_ok, pc_match;
    logic          unused_addr;

    // In IDLE the access operands come straight from the ports so a zero-wait access can fire immediately.
    assign d_req    = mem_rd_en_i | mem_wr_en_i;
    assign d_wr     = (state == IDLE) ? mem_wr_en_i : op_wr;
    assign d_ai     = (state == IDLE) ? (mem_wr_en_i ? addr_mem_wr_i[AW+2:3] : addr_mem_rd_i[AW+2:3]) : d_idx;
    assign d_wd     = (state == IDLE) ? data_mem_wr_i : wdata;
    assign f_pc     = (state == IDLE) ? pc_i : i_pc;
    assign f_idx    = f_pc[AW+2:3];
    assign pc_match = instr_rd_en_i && (pc_i == i_pc);
    assign f_ok     = (state == IDLE) || pc_match;
    assign d_fire   = state_nx == D_DONE;
    assign i_fire   = state_nx == I_DONE;

    assign stall_mem     = d_req && (state != D_DONE);
    assign stall_if      = instr_rd_en_i && !((state == I_DONE && fetch_ok && pc_match) || buf_hit);
    assign axi_idle_if_o = state != I_BUSY;
    assign unused_addr   = ^{addr_mem_rd_i[63:AW+3], addr_mem_rd_i[2:0], addr_mem_wr_i[63:AW+3], addr_mem_wr_i[2:0]};

`ifdef MEM_RESP_IFETCH_BUF_EN
    logic          buf_v;
    logic [AW-1:0] buf_idx;
    logic [63:0]   buf_dw;

    assign buf_hit = (state == IDLE) && !d_req && instr_rd_en_i && buf_v && (buf_idx == pc_i[AW+2:3]);
    assign f_dw    = buf_hit ? buf_dw : mem[f_idx];

    // Remember the last fetched doubleword; a store to that index invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v   <= 1'b0;
            buf_idx <= '0;
            buf_dw  <= '0;
        end else if (d_fire && d_wr && d_ai == buf_idx) begin
            buf_v <= 1'b0;
        end else if (i_fire) begin
            buf_v   <= 1'b1;
            buf_idx <= f_idx;
            buf_dw  <= mem[f_idx];
        end
    end
`else
    assign buf_hit = 1'b0;
    assign f_dw    = mem[f_idx];
`endif

    // Data requests beat fetches; each busy phase lasts WAIT_CYCLES cycles, then one DONE cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (d_req) state_nx = (WAIT_CYCLES == 0) ? D_DONE : D_BUSY;
                else if (instr_rd_en_i && !buf_hit) state_nx = (WAIT_CYCLES == 0) ? I_DONE : I_BUSY;
            end
            D_BUSY:  if (cnt == 4'd0) state_nx = D_DONE;
            I_BUSY:  if (cnt == 4'd0) state_nx = I_DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Store commits on the edge entering D_DONE; gated by reset so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (rst_n && d_fire && d_wr) mem[d_ai] <= d_wd;
    end

    // State, wait counter, request latches and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            op_wr        <= 1'b0;
            d_idx        <= '0;
            wdata        <= '0;
            i_pc         <= '0;
            fetch_ok     <= 1'b0;
            instr_o      <= 32'h0000_0013;
            addr_instr_o <= '0;
            data_mem_o   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == D_BUSY || state_nx == I_BUSY) cnt <= (state == IDLE) ? CNT_LOAD : cnt - 4'd1;
            if (state == IDLE) begin
                op_wr <= mem_wr_en_i;
                d_idx <= d_ai;
                wdata <= data_mem_wr_i;
                i_pc  <= pc_i;
            end
            if (d_fire && !d_wr) data_mem_o <= mem[d_ai];
            if (i_fire) fetch_ok <= f_ok;
            if ((i_fire && f_ok) || buf_hit) begin
                instr_o      <= f_pc[2] ? f_dw[63:32] : f_dw[31:0];
                addr_instr_o <= f_pc;
            end
        end
    end
endmodule
